// File: rtl/sub_serial.sv
// Bit-serial subtractor: a - b computed LSB first over WIDTH cycles with a ripple borrow flop.
// Load / shift / hold structure mirrors the serial adder.
module sub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
    end
  end

  assign diff = a_q[0] ^ b_q[0] ^ borrow_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          a_d      = a;
          b_d      = b;
          out_d    = '0;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = StSub;
        end
      end
      StSub: begin
        borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        out_d    = {diff, out_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LastCount) state_d = StDone;
      end
      StDone: begin
        // Held-high en parks here; a new start needs en to fall first.
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign out    = out_q;
  assign borrow = borrow_q;
  assign done   = (state_q == StDone);
  assign busy   = (state_q == StSub);

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: stimulus queues expected {borrow, out}; a monitor checks
// the result on every rising edge of done.
module tb_sub_serial;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             done;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];
  logic           done_prev = 1'b0;

  sub_serial #(.WIDTH(WIDTH), .CW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .out    (out),
    .borrow (borrow),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one result per done rising edge.
  always @(negedge clk) begin
    logic [WIDTH:0] exp;
    if (!rst && done && !done_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected done, got borrow=%0b out=%02h, no result queued",
                 borrow, out);
      end else begin
        exp = exp_q.pop_front();
        if ({borrow, out} !== exp) begin
          errors++;
          $display("FAIL result: got borrow=%0b out=%02h, expected borrow=%0b out=%02h",
                   borrow, out, exp[WIDTH], exp[WIDTH-1:0]);
        end
      end
    end
    done_prev = done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Load one operation and wait (bounded) for done; checks SUB length and latency.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH:0] exp, input bit scramble, input bit keep_en);
    int busy_cnt;
    int cyc;
    @(negedge clk);
    a = av;
    b = bv;
    en = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    if (!keep_en) en = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, WIDTH);
    check("busy_cycles", busy_cnt, WIDTH);
  endtask

  initial begin
    logic [WIDTH-1:0] held_out;
    rst = 1'b1;
    en = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_out", out, 0);
    check("reset_flags", {borrow, done, busy}, 3'b000);
    rst = 1'b0;

    run_op(8'h5A, 8'h23, {1'b0, 8'h37}, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, {1'b1, 8'hF0}, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, {1'b1, 8'hFF}, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, {1'b0, 8'hFE}, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, {1'b0, 8'h00}, 1'b0, 1'b0);

    // en held high: parks in DONE with a stable result.
    run_op(8'h5A, 8'h5B, {1'b1, 8'hFF}, 1'b0, 1'b1);
    held_out = out;
    repeat (4) @(negedge clk);
    check("hold_done", {done, busy}, 2'b10);
    check("hold_out", out, held_out);
    en = 1'b0;
    @(negedge clk);
    check("release_idle", {done, busy}, 2'b00);
    check("release_out_kept", out, held_out);
    run_op(8'h80, 8'h7F, {1'b0, 8'h01}, 1'b0, 1'b0);

    // Inputs scrambled during SUB must not affect the result.
    run_op(8'hC3, 8'h4D, {1'b0, 8'h76}, 1'b1, 1'b0);
    run_op(8'h4D, 8'hC3, {1'b1, 8'h8A}, 1'b1, 1'b0);

    // Asynchronous reset mid-operation, in the 4th SUB cycle.
    @(negedge clk);
    a = 8'hF0;
    b = 8'h0F;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out", out, 0);
    check("abort_flags", {borrow, done, busy}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h33, 8'h11, {1'b0, 8'h22}, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
